sig_dump_ctrl: RTL and testbench
================================

# sig_dump_ctrl

Hardware signature-dump engine for the RISC-V compliance flow. On the rising edge of the core's simulation-finish flag it latches the signature begin/end addresses (taken from t3/t4), sweeps that word range of TCM through a single-word read port, and streams each 32-bit word out on a valid/ready interface. The consumer is a UART or host-capture stage, so the signature can be collected without testbench hierarchical access.

## Interface
- ADDR_W, 17, TCM byte-address width; incoming addresses are truncated to this width.
- CNT_W, 16, width of the emitted-word counter.

- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- finish_i  in  1  simulation-finish level from the CSR file.
- begin_addr_i  in  32  signature start byte address (t3).
- end_addr_i  in  32  signature end byte address (t4), exclusive.
- mem_rd_o  out  1  one-cycle read strobe.
- mem_addr_o  out  ADDR_W  word-aligned byte address for the read.
- mem_data_i  in  32  read data, valid exactly 1 cycle after mem_rd_o.
- out_valid_o  out  1  output word valid.
- out_data_o  out  32  signature word.
- out_ready_i  in  1  consumer accept.
- busy_o  out  1  sweep in progress (state not IDLE/DONE).
- done_o  out  1  sweep complete.
- err_o  out  1  misaligned begin/end detected.
- word_count_o  out  CNT_W  words handed off in current/last sweep.

## Operation
- States: IDLE, CHECK, READ, WAIT, OUT, DONE.
- IDLE: on finish_i=1 with previous-cycle finish_i=0, latch cur=begin_addr_i[ADDR_W-1:0], end=end_addr_i[ADDR_W-1:0], clear word_count_o, err_o, done_o; go CHECK. A finish_i held high does not retrigger.
- CHECK (1 cycle): if cur[1:0]!=0 or end[1:0]!=0, set err_o and go DONE. Else if end<=cur (unsigned, ADDR_W bits), go DONE with 0 words. Else go READ.
- READ: mem_rd_o=1, mem_addr_o=cur; go WAIT.
- WAIT: capture mem_data_i into out_data_o register; go OUT.
- OUT: out_valid_o=1, out_data_o stable until out_valid_o&&out_ready_i. On handshake: cur+=4 (ADDR_W-bit wrap), word_count_o+=1. If cur+4>=end, go DONE; else go READ.
- DONE: done_o=1, busy_o=0. Hold until finish_i=0, then go IDLE. done_o, err_o and word_count_o keep their values in IDLE until the next trigger.
- mem_addr_o holds its last value when mem_rd_o=0. It is 0 after reset.

## Timing
- Reset (synchronous): state=IDLE. All outputs are 0: mem_rd_o, mem_addr_o, out_valid_o, out_data_o, busy_o, done_o, err_o, word_count_o. The finish edge detector is cleared, so finish_i high at reset release triggers only after it is seen high with previous low.
- A reset asserted mid-sweep aborts on the same clock edge. No further mem_rd_o. out_valid_o drops the next cycle.
- Timeline:
  - Trigger edge at cycle T: CHECK at T+1, first mem_rd_o at T+2, data captured at T+3, out_valid_o from T+4.
  - With out_ready_i tied 1, the sweep runs at 3 cycles per word.
  - After the last handshake at cycle H, done_o=1 from H+1.
- Valid/ready rules: out_valid_o never deasserts without a handshake. out_data_o never changes while out_valid_o=1 and out_ready_i=0. The block has no combinational path from out_ready_i to out_valid_o.
- Exactly one mem_rd_o per emitted word; no speculative reads.

## Test plan
- Basic sweep:
  - Stimulus: begin=0x2000, end=0x2010; TCM words 0x11111111, 0x22222222, 0x33333333, 0x44444444; ready=1.
  - Required response: those 4 words in order; mem_addr_o 0x2000,0x2004,0x2008,0x200C; word_count_o=4; done_o from 1 cycle after the last handshake; err_o=0.
- Backpressure:
  - Stimulus: same setup as basic sweep, with out_ready_i low for 5 cycles on word 2.
  - Required response: out_data_o=0x22222222 held stable; no extra mem_rd_o; total of 4 reads.
- Empty and error cases:
  - Stimulus: begin=end=0x3000. Required response: done_o 2 cycles after trigger; word_count_o=0; no mem_rd_o; err_o=0.
  - Stimulus: begin=0x3002, end=0x3010. Required response: err_o=1; done_o=1; zero reads.
- Truncation and retrigger:
  - Stimulus: begin=0xABC12000, end=0xABC12008. Required response: reads at 0x12000 and 0x12004.
  - Stimulus: finish_i held high through DONE. Required response: no second sweep.
  - Stimulus: finish_i dropped then raised. Required response: new sweep with word_count_o restarting from 0.
- Reset mid-sweep:
  - Stimulus: assert rst_i one cycle while out_valid_o=1 on word 2.
  - Required response: all outputs 0 at the next edge; a later finish edge gives a full, correct sweep.

Source files
------------

// File: rtl/sig_dump_ctrl.sv
// Signature-dump engine: on a rising finish flag, sweeps a TCM word range
// through a single-word read port and streams each word out over valid/ready.
module sig_dump_ctrl #(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              finish_i,
  input  logic [31:0]       begin_addr_i,
  input  logic [31:0]       end_addr_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_data_i,
  output logic              out_valid_o,
  output logic [31:0]       out_data_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  word_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              fin_prev_q;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              trigger;
  logic [ADDR_W-1:0] cur_inc;

  assign trigger = finish_i & ~fin_prev_q;
  assign cur_inc = cur_q + ADDR_W'(4);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          cur_d   = begin_addr_i[ADDR_W-1:0];
          end_d   = end_addr_i[ADDR_W-1:0];
          cnt_d   = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cur_q[1:0] != 2'b00 || end_q[1:0] != 2'b00) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (end_q <= cur_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          mem_addr_d = cur_q;
          state_d    = S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        data_d  = mem_data_i;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready_i) begin
          cur_d = cur_inc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cur_inc >= end_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            // Address is registered on entry to READ so it holds between reads.
            mem_addr_d = cur_inc;
            state_d    = S_READ;
          end
        end
      end
      S_DONE: begin
        if (!finish_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      fin_prev_q <= 1'b0;
      cur_q      <= '0;
      end_q      <= '0;
      mem_addr_q <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fin_prev_q <= finish_i;
      cur_q      <= cur_d;
      end_q      <= end_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_rd_o     = (state_q == S_READ);
  assign mem_addr_o   = mem_addr_q;
  assign out_valid_o  = (state_q == S_OUT);
  assign out_data_o   = data_q;
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = cnt_q;

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Self-checking bench for sig_dump_ctrl: directed and random sweeps compared
// against a word-list model derived from begin/end addresses.
module tb_sig_dump_ctrl;
  localparam int ADDR_W = 17;
  localparam int CNT_W  = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              finish_i;
  logic [31:0]       begin_addr_i;
  logic [31:0]       end_addr_i;
  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_i;
  logic              out_valid_o;
  logic [31:0]       out_data_o;
  logic              out_ready_i = 1'b1;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [CNT_W-1:0]  word_count_o;

  sig_dump_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .finish_i     (finish_i),
    .begin_addr_i (begin_addr_i),
    .end_addr_i   (end_addr_i),
    .mem_rd_o     (mem_rd_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_i   (mem_data_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_ready_i  (out_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .word_count_o (word_count_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // TCM contents: the test-plan words at 0x2000..0x200C, a hash elsewhere.
  function automatic logic [31:0] tcm(input logic [ADDR_W-1:0] a);
    int off;
    off = int'(a) - 8192;
    if (off >= 0 && off < 16) return 32'h1111_1111 * (off / 4 + 1);
    return ({15'd0, a} * 32'h9E37_79B1) ^ 32'h3C5A_96E1;
  endfunction

  // Observation logs (owned by the monitor only).
  logic [ADDR_W-1:0] rd_addr_q[$];
  int                rd_cyc_q[$];
  logic [31:0]       hs_data_q[$];
  int                hs_cyc_q[$];
  int                hold_err  = 0;
  int                hold_seen = 0;
  bit                prev_stall = 1'b0;
  logic [31:0]       prev_data;
  bit                pend = 1'b0;
  logic [ADDR_W-1:0] pend_addr;

  // Memory responder and monitor; data is valid only in the cycle after the strobe.
  always @(negedge clk_i) begin
    mem_data_i = pend ? tcm(pend_addr) : $urandom;
    pend       = mem_rd_o && !rst_i;
    pend_addr  = mem_addr_o;
    if (!rst_i) begin
      if (mem_rd_o) begin
        rd_addr_q.push_back(mem_addr_o);
        rd_cyc_q.push_back(cyc);
      end
      if (out_valid_o && out_ready_i) begin
        hs_data_q.push_back(out_data_o);
        hs_cyc_q.push_back(cyc);
      end
      if (prev_stall) begin
        hold_seen++;
        if (out_valid_o !== 1'b1 || out_data_o !== prev_data) hold_err++;
      end
    end
    prev_stall = out_valid_o && !out_ready_i && !rst_i;
    prev_data  = out_data_o;
  end

  // Ready driver: mode 0 = always ready, 1 = random, 2 = five stalled cycles on word 2.
  int rmode      = 0;
  int hs_base    = 0;
  int stall_used = 0;
  always @(posedge clk_i) begin
    #1;
    if (hs_data_q.size() - hs_base == 0) stall_used = 0;
    if (rmode == 2 && hs_data_q.size() - hs_base == 1 && out_valid_o && stall_used < 5) begin
      out_ready_i = 1'b0;
      stall_used++;
    end else if (rmode == 1) begin
      out_ready_i = 1'($urandom_range(0, 1));
    end else begin
      out_ready_i = 1'b1;
    end
  end

  task automatic outs_zero(input string tag);
    check({tag, "_rd"},    32'(mem_rd_o),     32'd0);
    check({tag, "_addr"},  32'(mem_addr_o),   32'd0);
    check({tag, "_valid"}, 32'(out_valid_o),  32'd0);
    check({tag, "_data"},  out_data_o,        32'd0);
    check({tag, "_busy"},  32'(busy_o),       32'd0);
    check({tag, "_done"},  32'(done_o),       32'd0);
    check({tag, "_err"},   32'(err_o),        32'd0);
    check({tag, "_cnt"},   32'(word_count_o), 32'd0);
  endtask

  task automatic run_sweep(input logic [31:0] b, input logic [31:0] e, input int mode,
                           input bit drop);
    logic [ADDR_W-1:0] b_t, e_t, a;
    bit misal;
    int n, t0, done_cyc, wait_n, rb, hb, he0, nr, nh;
    b_t   = b[ADDR_W-1:0];
    e_t   = e[ADDR_W-1:0];
    misal = (b_t[1:0] != 2'b00) || (e_t[1:0] != 2'b00);
    n     = (!misal && e_t > b_t) ? int'(e_t - b_t) / 4 : 0;
    rb    = rd_addr_q.size();
    hb    = hs_data_q.size();
    he0   = hold_err;
    hs_base = hb;
    rmode   = mode;

    @(posedge clk_i); #1;
    begin_addr_i = b;
    end_addr_i   = e;
    finish_i     = 1'b1;
    t0           = cyc;

    @(negedge clk_i);
    @(negedge clk_i);
    check("start_cnt_clear", 32'(word_count_o), 32'd0);
    check("start_busy",      32'(busy_o),       32'd1);
    check("start_done_clr",  32'(done_o),       32'd0);

    wait_n = 0;
    while (done_o !== 1'b1 && wait_n < 3000) begin
      @(negedge clk_i);
      wait_n++;
    end
    if (done_o !== 1'b1) check("done_timeout", 32'(done_o), 32'd1);
    done_cyc = cyc;

    nr = rd_addr_q.size() - rb;
    nh = hs_data_q.size() - hb;
    check("num_reads", nr, n);
    check("num_words", nh, n);
    for (int i = 0; i < n && i < nr; i++) begin
      a = b_t + ADDR_W'(4 * i);
      check("rd_addr", 32'(rd_addr_q[rb + i]), 32'(a));
    end
    for (int i = 0; i < n && i < nh; i++) begin
      a = b_t + ADDR_W'(4 * i);
      check("word_data", hs_data_q[hb + i], tcm(a));
      if (mode == 0) check("word_time", hs_cyc_q[hb + i], t0 + 4 + 3 * i);
    end
    if (n > 0 && nr > 0) check("first_rd_time", rd_cyc_q[rb], t0 + 2);
    if (n == 0)       check("done_time", done_cyc, t0 + 2);
    else if (nh >= n) check("done_time", done_cyc, hs_cyc_q[hb + n - 1] + 1);
    check("end_cnt",  32'(word_count_o), n);
    check("end_err",  32'(err_o),        32'(misal));
    check("end_busy", 32'(busy_o),       32'd0);
    check("hold_stable", hold_err - he0, 0);

    if (drop) begin
      @(posedge clk_i); #1;
      finish_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("idle_done_kept", 32'(done_o),       32'd1);
      check("idle_cnt_kept",  32'(word_count_o), n);
      check("idle_err_kept",  32'(err_o),        32'(misal));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b, e;
    int rb, hs0, wait_n, len;
    bit hit;

    rst_i        = 1'b1;
    finish_i     = 1'b0;
    begin_addr_i = '0;
    end_addr_i   = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    outs_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    outs_zero("post_reset");

    // Basic sweep.
    run_sweep(32'h0000_2000, 32'h0000_2010, 0, 1'b1);

    // Backpressure on word 2.
    hs0 = hold_seen;
    run_sweep(32'h0000_2000, 32'h0000_2010, 2, 1'b1);
    check("bp_stall_cycles", hold_seen - hs0, 5);

    // Empty and misaligned.
    run_sweep(32'h0000_3000, 32'h0000_3000, 0, 1'b1);
    run_sweep(32'h0000_3002, 32'h0000_3010, 0, 1'b1);

    // Truncation of upper address bits.
    run_sweep(32'hABC1_2000, 32'hABC1_2008, 0, 1'b1);

    // Finish held high through DONE must not retrigger.
    run_sweep(32'h0000_2000, 32'h0000_2008, 0, 1'b0);
    rb = rd_addr_q.size();
    repeat (20) @(negedge clk_i);
    check("held_no_reads", rd_addr_q.size() - rb, 0);
    check("held_done",     32'(done_o),       32'd1);
    check("held_cnt",      32'(word_count_o), 32'd2);
    @(posedge clk_i); #1;
    finish_i = 1'b0;
    repeat (3) @(negedge clk_i);
    run_sweep(32'h0000_2000, 32'h0000_2010, 0, 1'b1);

    // Reset while word 2 is valid and stalled.
    hs_base = hs_data_q.size();
    rmode   = 2;
    @(posedge clk_i); #1;
    begin_addr_i = 32'h0000_2000;
    end_addr_i   = 32'h0000_2010;
    finish_i     = 1'b1;
    wait_n = 0;
    hit    = 1'b0;
    while (!hit && wait_n < 200) begin
      @(negedge clk_i);
      wait_n++;
      hit = (hs_data_q.size() - hs_base == 1) && out_valid_o === 1'b1 && out_ready_i === 1'b0;
    end
    check("rst_stall_reached", 32'(hit), 32'd1);
    @(posedge clk_i); #1;
    rst_i    = 1'b1;
    finish_i = 1'b0;
    rmode    = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    rb    = rd_addr_q.size();
    @(negedge clk_i);
    outs_zero("mid_reset");
    repeat (5) @(negedge clk_i);
    check("mid_reset_no_reads", rd_addr_q.size() - rb, 0);
    run_sweep(32'h0000_2000, 32'h0000_2010, 0, 1'b1);

    // Random sweeps with random consumer readiness.
    repeat (20) begin
      b      = $urandom;
      b[16]  = 1'b0;
      b[8]   = 1'b1;
      b[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      len    = $urandom_range(0, 10);
      e      = b + 32'(len * 4);
      e[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) e = b - 32'd8;
      run_sweep(b, e, 1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
